// File: rtl/sub_64bit_seq.sv
// Multi-cycle WIDTH-bit subtractor (Diff = A - B) computed SLICE_W bits per clock, plus ZF/SF/OF/borrow flags.
// Latency: start accepted at edge E0, done pulses for one cycle after edge E(NUM_SLICES).
// Backpressure: start is honoured only in IDLE; while busy it is ignored (no restart, no queuing).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    request pulse, sampled only in IDLE
//   A, B     minuend / subtrahend, latched on the accepting edge
//   busy     high while the slices are being computed
//   done     one-cycle pulse; Diff and flags are valid from this cycle on
//   Diff     A - B modulo 2^WIDTH
//   borrow   1 iff A < B unsigned (inverted final carry)
//   overflow signed overflow of the subtraction
//   zero     Diff == 0
//   sign     Diff[WIDTH-1]
module sub_64bit_seq #(
  parameter int WIDTH      = 64,
  parameter int SLICE_W    = 16,
  parameter int NUM_SLICES = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] bn_l;      // subtrahend stored already inverted
  logic             carry;
  logic             zero_acc;  // all slices written so far in this operation are zero

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W:0]   sum;
  logic [WIDTH-1:0]   diff_nxt;
  logic               last_slice;
  logic               sum_zero;

  // Select the current slice of both operands and merge the new sum slice
  // into Diff; only the addressed slice changes, the rest hold.
  always_comb begin
    a_sl     = '0;
    b_sl     = '0;
    diff_nxt = Diff;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_l[i*SLICE_W +: SLICE_W];
        b_sl = bn_l[i*SLICE_W +: SLICE_W];
      end
    end
    sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry};
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx == IDX_W'(i)) begin
        diff_nxt[i*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
      end
    end
    last_slice = (idx == IDX_W'(NUM_SLICES - 1));
    sum_zero   = (sum[SLICE_W-1:0] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      a_l      <= '0;
      bn_l     <= '0;
      carry    <= 1'b0;
      zero_acc <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sign     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          // carry-in of 1 with ~B turns the adder into A - B
          a_l      <= A;
          bn_l     <= ~B;
          carry    <= 1'b1;
          idx      <= '0;
          zero_acc <= 1'b1;
          busy     <= 1'b1;
          state    <= CALC;
        end
      end else begin
        Diff  <= diff_nxt;
        carry <= sum[SLICE_W];
        if (last_slice) begin
          borrow   <= ~sum[SLICE_W];
          sign     <= sum[SLICE_W-1];
          zero     <= zero_acc & sum_zero;
          // A and B signs differ exactly when a_l and the inverted B agree
          overflow <= (a_l[WIDTH-1] == bn_l[WIDTH-1]) &&
                      (sum[SLICE_W-1] != a_l[WIDTH-1]);
          done     <= 1'b1;
          busy     <= 1'b0;
          idx      <= '0;
          state    <= IDLE;
        end else begin
          idx      <= idx + 1'b1;
          zero_acc <= zero_acc & sum_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_64bit_seq.sv
module tb_sub_64bit_seq;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        busy;
  logic        done;
  logic [63:0] Diff;
  logic        borrow;
  logic        overflow;
  logic        zero;
  logic        sign;

  sub_64bit_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Diff     (Diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    logic        s;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed overflow from a 65-bit signed difference.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int due);
    exp_t e;
    logic signed [64:0] sd;
    sd   = $signed({a[63], a}) - $signed({b[63], b});
    e.d  = a - b;
    e.bo = (a < b);
    e.ov = (sd > 65'sd9223372036854775807) || (sd < -65'sd9223372036854775808);
    e.z  = (e.d == 64'd0);
    e.s  = e.d[63];
    e.due = due;
    return e;
  endfunction

  // Monitor: compares every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", Diff, e.d);
          chk("borrow", {63'd0, borrow}, {63'd0, e.bo});
          chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
          chk("zero", {63'd0, zero}, {63'd0, e.z});
          chk("sign", {63'd0, sign}, {63'd0, e.s});
          chk("latency", 64'(cyc), 64'(e.due));
          chk("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        chk("missing_done", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle). Keeps start
  // high for 'hold' extra cycles with scrambled operands, which must be ignored.
  task automatic go(input logic [63:0] a, input logic [63:0] b, input int hold);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc + NS));
    repeat (hold) begin
      @(negedge clk);
      A = rnd64();
      B = rnd64();
    end
    @(negedge clk);
    start = 1'b0;
    A = rnd64();
    B = rnd64();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_diff"}, Diff, 64'd0);
    chk({tag, "_flags"}, {60'd0, borrow, overflow, zero, sign}, 64'd0);
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b);
    go(a, b, 0);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of an operation discards it.
    go(64'd10, 64'd3, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("midop");
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);   // monitor flags any stray done here

    // Directed cases.
    run(64'd10, 64'd3);
    run(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    run(64'd3, 64'd10);
    run(64'h8000_0000_0000_0000, 64'd1);
    run(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run(64'h0000_0000_0001_0000, 64'd1);
    run(64'd0, 64'd0);

    // start held through CALC with changing operands, then start in done cycle.
    go(64'd1000, 64'd1, 3);
    wait_done();
    go(64'd5, 64'd5, 0);
    wait_done();
    @(negedge clk);

    // Randomised traffic: corner picks, holds, back-to-back issue.
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = rnd64();
      b = rnd64();
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 64'd0;
        2: b = {1'b1, 63'd0};
        3: a = {a[63], 47'h0, a[15:0]};
        default: ;
      endcase
      go(a, b, $urandom_range(0, 3));
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
